// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

  // Sequencer states: waiting for a request, stepping nibbles, reporting.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT  = 32;
  localparam int SLICE          = 4;
  localparam int NSTEPS_DEFAULT = WIDTH_DEFAULT / SLICE;
  localparam int STEP_W_DEFAULT = $clog2(NSTEPS_DEFAULT);

  // Width of a counter that indexes nsteps steps; at least one bit.
  function automatic int step_width(input int nsteps);
    return (nsteps > 1) ? $clog2(nsteps) : 1;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice with full generate/propagate terms.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             c3,
  output logic             c4
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;

  // Per-bit propagate/generate and sum bits.
  for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
    assign p[gi] = a[gi] ^ b[gi];
    assign g[gi] = a[gi] & b[gi];
    assign s[gi] = p[gi] ^ c[gi];
  end

  // Every carry is expanded directly from cin so no carry waits on another.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign c3 = c[3];
  assign c4 = c[4];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle adder/subtractor: one 4-bit CLA slice stepped across the
// operand nibbles LSB first, with the inter-nibble carry held in a register.
module cla_nibble_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NSTEPS = WIDTH / SLICE;
  localparam int STEP_W = step_width(NSTEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_width_check
    $error("WIDTH must be a non-zero multiple of the slice width");
  end

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [WIDTH-1:0]    opa_q, opa_d;
  logic [WIDTH-1:0]    opb_q, opb_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                carry_q;
  logic                c_out_q;
  logic                ovf_q;
  logic                busy_q;
  logic                done_q;

  logic [SLICE-1:0]    slice_s;
  logic                slice_c3;
  logic                slice_c4;

  cla4_slice u_slice (
    .a   (opa_q[SLICE-1:0]),
    .b   (opb_q[SLICE-1:0]),
    .cin (carry_q),
    .s   (slice_s),
    .c3  (slice_c3),
    .c4  (slice_c4)
  );

  // Operands drain from the bottom; each slice sum enters the result at the
  // top so that after the last step the result is in its natural position.
  always_comb begin
    opa_d    = opa_q >> SLICE;
    opb_d    = opb_q >> SLICE;
    result_d = {slice_s, result_q[WIDTH-1:SLICE]};
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtract is A + ~B + 1; the external carry-in is ignored then.
            opa_q   <= a;
            opb_q   <= op_sub ? ~b : b;
            carry_q <= op_sub ? 1'b1 : c_in;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          opa_q    <= opa_d;
          opb_q    <= opb_d;
          result_q <= result_d;
          carry_q  <= slice_c4;
          step_q   <= step_q + 1'b1;
          if (step_q == LAST_STEP) begin
            // Top nibble: c3 is the carry into the MSB, c4 the carry out.
            c_out_q <= slice_c4;
            ovf_q   <= slice_c3 ^ slice_c4;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = result_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench: directed vector table, handshake/reset sequences and
// randomized operations checked against an arithmetic reference model.
module tb_cla_nibble_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        c_in = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        c_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  cla_nibble_sequencer #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; overflow means the true signed
  // result falls outside the 32-bit two's-complement range.
  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic sub, input logic cin);
    logic [32:0] full;
    longint      sa, sb, r;
    logic        ovf;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (sub) begin
      full = {1'b0, av} + {1'b0, ~bv} + 33'd1;
      r    = sa - sb;
    end else begin
      full = {1'b0, av} + {1'b0, bv} + {32'd0, cin};
      r    = sa + sb + longint'(cin);
    end
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {ovf, full[32], full[31:0]};
  endfunction

  // Called at #1 after an edge while IDLE. Returns results seen in the done
  // cycle and the number of edges after the accepting edge until done.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic sub, input logic cin,
                        output logic [31:0] s, output logic co, output logic ov,
                        output int lat, output int busy_low_in_run);
    start = 1'b1; a = av; b = bv; op_sub = sub; c_in = cin;
    @(posedge clock); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op_sub = 1'($urandom); c_in = 1'($urandom);
    lat = -1;
    busy_low_in_run = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_low_in_run++;
    end
    s = sum; co = c_out; ov = overflow;
  endtask

  // One edge after the done cycle: pulse is over, block idle, result held.
  task automatic after_done(input logic [31:0] exp_sum, input logic exp_cout);
    @(posedge clock); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy_low", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    chk("sum_hold", sum, exp_sum);
    chk("cout_hold", {31'd0, c_out}, {31'd0, exp_cout});
  endtask

  task automatic do_checked_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                               input logic sub, input logic cin, input logic [31:0] es,
                               input logic eco, input logic eov);
    logic [31:0] s;
    logic        co, ov;
    int          lat, bl;
    run_op(av, bv, sub, cin, s, co, ov, lat, bl);
    $display("%s: a=%08h b=%08h sub=%0d cin=%0d -> sum=%08h c_out=%0d ovf=%0d lat=%0d",
             tag, av, bv, sub, cin, s, co, ov, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_busy_in_run"}, 32'(bl), 32'd0);
    chk({tag, "_sum"}, s, es);
    chk({tag, "_cout"}, {31'd0, co}, {31'd0, eco});
    chk({tag, "_ovf"}, {31'd0, ov}, {31'd0, eov});
    after_done(es, eco);
  endtask

  initial begin
    logic [33:0] m;
    logic [31:0] ra, rb;
    logic        rs, rc;
    int          done_seen;
    int          lat;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'hEDCB_A987, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'hEDCB_A987, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", {31'd0, c_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      do_checked_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                    vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // Handshake: start pulsed mid-RUN is ignored; start held through DONE is
    // accepted on the first IDLE edge.
    start = 1'b1; a = 32'h0000_0100; b = 32'h0000_0023; op_sub = 1'b0; c_in = 1'b0;
    @(posedge clock); #1;                      // accepting edge T
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end // after T+3
    start = 1'b1; a = 32'hDEAD_0000; b = 32'h0000_BEEF; op_sub = 1'b1;
    @(posedge clock); #1;                      // T+4
    start = 1'b0;
    chk("hs_busy_after_pulse", {31'd0, busy}, 32'd1);
    @(posedge clock); #1;                      // T+5
    @(posedge clock); #1;                      // T+6
    start = 1'b1; a = 32'hFFFF_FFF0; b = 32'h0000_0020; op_sub = 1'b0; c_in = 1'b0;
    @(posedge clock); #1;                      // T+7
    chk("hs_busy_t7", {31'd0, busy}, 32'd1);
    chk("hs_done_t7", {31'd0, done}, 32'd0);
    @(posedge clock); #1;                      // T+8: DONE
    chk("hs_done_t8", {31'd0, done}, 32'd1);
    chk("hs_busy_t8", {31'd0, busy}, 32'd0);
    chk("hs_first_sum", sum, 32'h0000_0123);
    @(posedge clock); #1;                      // T+9: IDLE, start still high
    chk("hs_done_t9", {31'd0, done}, 32'd0);
    chk("hs_busy_t9", {31'd0, busy}, 32'd0);
    chk("hs_sum_t9", sum, 32'h0000_0123);
    @(posedge clock); #1;                      // T+10: accepted
    chk("hs_busy_t10", {31'd0, busy}, 32'd1);
    start = 1'b0; a = $urandom; b = $urandom;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    $display("handshake: second op sum=%08h c_out=%0d lat=%0d", sum, c_out, lat);
    chk("hs_second_latency", 32'(lat), 32'd8);
    chk("hs_second_sum", sum, 32'h0000_0010);
    chk("hs_second_cout", {31'd0, c_out}, 32'd1);
    after_done(32'h0000_0010, 1'b1);

    // Reset mid-operation at step 4
    start = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222; op_sub = 1'b0; c_in = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum", sum, 32'd0);
    chk("midrst_cout", {31'd0, c_out}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    $display("reset mid-run: done pulses afterwards=%0d", done_seen);
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    do_checked_op("post_reset_add", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFF_FFFF;
        1: rb = 32'h8000_0000;
        2: rb = ~ra;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      m = model(ra, rb, rs, rc);
      do_checked_op($sformatf("rand%0d", i), ra, rb, rs, rc, m[31:0], m[32], m[33]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
